// File: rtl/scan_chain_datapath.sv
// Stimulus/response scan datapath: serial load + rotate-launch stimulus chain,
// serial unload + MISR response chain, with load/capture progress counters.
module scan_chain_datapath #(
  parameter int N1 = 200,
  parameter int N2 = 7
) (
  input  logic          Clock,
  input  logic          nReset,
  input  logic          Inkeep,
  input  logic          Inshift,
  input  logic          Outkeep,
  input  logic          Outshift,
  input  logic          Start2,
  input  logic          SerIn,
  input  logic [N1-1:0] DutResp,
  output logic [N1-1:0] DutStim,
  output logic          SerOut,
  output logic [9:0]    InCount,
  output logic          LoadDone,
  output logic [3:0]    CapCount,
  output logic          CapOk
);

  // Targets that cannot be represented in the counter width disable their flag.
  localparam bit         LOAD_REACHABLE = (N1 <= 1023);
  localparam logic [9:0] LOAD_TARGET    = LOAD_REACHABLE ? 10'(N1) : 10'd0;
  localparam bit         CAP_REACHABLE  = (N2 >= 0) && (N2 + 1 <= 15);
  localparam logic [3:0] CAP_TARGET     = CAP_REACHABLE ? 4'(N2 + 1) : 4'd0;

  if (N1 > 1023) begin : g_n1_warn
    $warning("scan_chain_datapath: N1=%0d exceeds InCount range, LoadDone will never assert", N1);
  end

  logic [N1-1:0] r_stim;
  logic [N1-1:0] r_resp;
  logic [9:0]    r_in_cnt;
  logic [3:0]    r_cap_cnt;
  logic          r_load_done;
  logic          r_cap_ok;

  logic          w_load;
  logic          w_cap;
  logic [9:0]    w_in_base;
  logic [9:0]    w_in_next;
  logic [3:0]    w_cap_base;
  logic [3:0]    w_cap_next;

  assign w_load = !Inkeep && !Inshift;
  assign w_cap  = !Outkeep && !Outshift;

  // Start2 clears first, then the same-cycle increment is applied on top.
  assign w_in_base  = Start2 ? 10'd0 : r_in_cnt;
  assign w_in_next  = (w_load && (w_in_base != 10'h3FF)) ? w_in_base + 10'd1 : w_in_base;
  assign w_cap_base = Start2 ? 4'd0 : r_cap_cnt;
  assign w_cap_next = (w_cap && (w_cap_base != 4'hF)) ? w_cap_base + 4'd1 : w_cap_base;

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      r_stim      <= '0;
      r_resp      <= '0;
      r_in_cnt    <= '0;
      r_cap_cnt   <= '0;
      r_load_done <= 1'b0;
      r_cap_ok    <= 1'b0;
    end else begin
      if (!Inkeep) begin
        if (Inshift) r_stim <= {r_stim[N1-2:0], r_stim[N1-1]};
        else         r_stim <= {r_stim[N1-2:0], SerIn};
      end
      if (!Outkeep) begin
        if (Outshift) r_resp <= {r_resp[N1-2:0], 1'b0};
        else          r_resp <= {r_resp[N1-2:0], r_resp[N1-1]} ^ DutResp;
      end
      r_in_cnt    <= w_in_next;
      r_cap_cnt   <= w_cap_next;
      r_load_done <= LOAD_REACHABLE && (w_in_next >= LOAD_TARGET);
      r_cap_ok    <= CAP_REACHABLE && (w_cap_next == CAP_TARGET);
    end
  end

  assign DutStim  = r_stim;
  assign SerOut   = r_resp[N1-1];
  assign InCount  = r_in_cnt;
  assign LoadDone = r_load_done;
  assign CapCount = r_cap_cnt;
  assign CapOk    = r_cap_ok;

endmodule
